mmc_game_param: RTL

Parametrised multi-mode counter game. A WIDTH-bit up/down counter with two configurable step sizes awards a loser point at count zero and a winner point at all-ones, and keeps saturating-free scores. A three-state controller (IDLE/PLAY/OVER) holds the final result until acknowledged. It replaces the fixed 3-bit game core and adds start/acknowledge handshakes, programmable step and win score, and visible scores.

---
 rtl/mmc_game_param.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mmc_game_param.sv
// Multi-mode up/down counter game: counts with two step sizes and scores hits at zero and
// all-ones. Gameplay runs IDLE -> PLAY -> OVER, and each acknowledge starts a new PLAY round.
module mmc_game_param #(
    parameter int WIDTH     = 3,
    parameter int STEP_HI   = 2,
    parameter int SCORE_W   = 4,
    parameter int WIN_SCORE = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               ack,
    input  logic [1:0]         ctrl,
    input  logic               init,
    input  logic [WIDTH-1:0]   init_val,
    output logic [WIDTH-1:0]   count,
    output logic               winner,
    output logic               loser,
    output logic [SCORE_W-1:0] winner_count,
    output logic [SCORE_W-1:0] loser_count,
    output logic               gameover,
    output logic [1:0]         who,
    output logic [1:0]         state
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_OVER = 2'b10;

    localparam logic [WIDTH-1:0]   CNT_MAX   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   CNT_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   STEP_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   STEP_BIG  = WIDTH'(STEP_HI);
    localparam logic [SCORE_W-1:0] SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};
    localparam logic [SCORE_W-1:0] SCORE_END = SCORE_W'(WIN_SCORE - 1);

    logic [1:0]         state_r, state_s;
    logic [WIDTH-1:0]   count_r, count_s;
    logic               winner_r, winner_s;
    logic               loser_r, loser_s;
    logic [SCORE_W-1:0] wcount_r, wcount_s;
    logic [SCORE_W-1:0] lcount_r, lcount_s;
    logic               gameover_r, gameover_s;
    logic [1:0]         who_r, who_s;

    logic [WIDTH-1:0]   step_s;
    logic [WIDTH-1:0]   stepped_s;
    logic               win_end_s;
    logic               lose_end_s;

    // Step arithmetic and end-of-game detection.
    always_comb begin
        step_s     = ctrl[0] ? STEP_BIG : STEP_ONE;
        stepped_s  = ctrl[1] ? (count_r - step_s) : (count_r + step_s);
        win_end_s  = winner_r && (wcount_r == SCORE_END);
        lose_end_s = loser_r && (lcount_r == SCORE_END);
    end

    // Next-state logic for the controller, counter, flags and scores.
    always_comb begin
        state_s    = state_r;
        count_s    = count_r;
        winner_s   = 1'b0;
        loser_s    = 1'b0;
        wcount_s   = wcount_r;
        lcount_s   = lcount_r;
        gameover_s = gameover_r;
        who_s      = who_r;
        case (state_r)
            ST_IDLE: begin
                if (init) begin
                    count_s = init_val;
                end else begin
                    count_s = count_r;
                end
                if (start) begin
                    state_s = ST_PLAY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                count_s  = init ? init_val : stepped_s;
                // Flags come from the count before this edge's update.
                winner_s = (count_r == CNT_MAX);
                loser_s  = (count_r == CNT_ZERO);
                if (winner_r) begin
                    wcount_s = wcount_r + SCORE_ONE;
                end else begin
                    wcount_s = wcount_r;
                end
                if (loser_r) begin
                    lcount_s = lcount_r + SCORE_ONE;
                end else begin
                    lcount_s = lcount_r;
                end
                if (win_end_s || lose_end_s) begin
                    state_s    = ST_OVER;
                    gameover_s = 1'b1;
                    who_s      = win_end_s ? 2'b10 : 2'b01;
                    winner_s   = 1'b0;
                    loser_s    = 1'b0;
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (ack) begin
                    state_s    = ST_PLAY;
                    wcount_s   = {SCORE_W{1'b0}};
                    lcount_s   = {SCORE_W{1'b0}};
                    gameover_s = 1'b0;
                end else begin
                    state_s = ST_OVER;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                count_s    = CNT_ZERO;
                wcount_s   = {SCORE_W{1'b0}};
                lcount_s   = {SCORE_W{1'b0}};
                gameover_s = 1'b0;
                who_s      = 2'b00;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            count_r    <= CNT_ZERO;
            winner_r   <= 1'b0;
            loser_r    <= 1'b0;
            wcount_r   <= {SCORE_W{1'b0}};
            lcount_r   <= {SCORE_W{1'b0}};
            gameover_r <= 1'b0;
            who_r      <= 2'b00;
        end else begin
            state_r    <= state_s;
            count_r    <= count_s;
            winner_r   <= winner_s;
            loser_r    <= loser_s;
            wcount_r   <= wcount_s;
            lcount_r   <= lcount_s;
            gameover_r <= gameover_s;
            who_r      <= who_s;
        end
    end

    assign count        = count_r;
    assign winner       = winner_r;
    assign loser        = loser_r;
    assign winner_count = wcount_r;
    assign loser_count  = lcount_r;
    assign gameover     = gameover_r;
    assign who          = who_r;
    assign state        = state_r;

endmodule
